// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: per-source one-entry holding buffers drained one per cycle
// into a registered register-file write port, fixed priority with starvation override.
module wb_write_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_SOURCES  = 3,
    parameter int DEPTH        = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                                        i_clk,
    input  logic                                        i_rst,
    input  logic [NUM_SOURCES-1:0]                      i_src_valid,
    output logic [NUM_SOURCES-1:0]                      o_src_ready,
    input  logic [NUM_SOURCES*$clog2(DEPTH)-1:0]        i_src_addr,
    input  logic [NUM_SOURCES*DATA_WIDTH-1:0]           i_src_data,
    input  logic                                        i_stall,
    output logic                                        o_write_enable,
    output logic [$clog2(DEPTH)-1:0]                    o_write_addr,
    output logic [DATA_WIDTH-1:0]                       o_write_data,
    output logic [NUM_SOURCES-1:0]                      o_grant
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int WAIT_W     = $clog2(STARVE_LIMIT + 1);

    logic [NUM_SOURCES-1:0] buf_valid;
    logic [ADDR_WIDTH-1:0]  buf_addr [NUM_SOURCES];
    logic [DATA_WIDTH-1:0]  buf_data [NUM_SOURCES];
    logic [WAIT_W-1:0]      wait_cnt [NUM_SOURCES];

    logic [NUM_SOURCES-1:0] gnt;
    logic [NUM_SOURCES-1:0] load;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic                   starved_found;
    logic                   normal_found;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        gnt           = '0;
        starved_found = 1'b0;
        normal_found  = 1'b0;
        if (!i_stall) begin
            for (int i = 0; i < NUM_SOURCES; i++) begin
                if (!starved_found && buf_valid[i] && wait_cnt[i] == WAIT_W'(STARVE_LIMIT)) begin
                    gnt[i]        = 1'b1;
                    starved_found = 1'b1;
                end
            end
            if (!starved_found) begin
                for (int i = 0; i < NUM_SOURCES; i++) begin
                    if (!normal_found && buf_valid[i]) begin
                        gnt[i]       = 1'b1;
                        normal_found = 1'b1;
                    end
                end
            end
        end
    end

    // gnt is one-hot or zero, so an OR of masked entries is the selected entry.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (gnt[i]) begin
                sel_addr = sel_addr | buf_addr[i];
                sel_data = sel_data | buf_data[i];
            end
        end
    end

    assign o_src_ready = {NUM_SOURCES{~i_rst}} & (~buf_valid | gnt);
    assign load        = i_src_valid & o_src_ready;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            buf_valid      <= '0;
            o_write_enable <= 1'b0;
            o_write_addr   <= '0;
            o_write_data   <= '0;
            o_grant        <= '0;
            for (int i = 0; i < NUM_SOURCES; i++) wait_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_SOURCES; i++) begin
                if (load[i])     buf_valid[i] <= 1'b1;
                else if (gnt[i]) buf_valid[i] <= 1'b0;
            end
            if (!i_stall) begin
                for (int i = 0; i < NUM_SOURCES; i++) begin
                    if (gnt[i])
                        wait_cnt[i] <= '0;
                    else if (buf_valid[i] && wait_cnt[i] != WAIT_W'(STARVE_LIMIT))
                        wait_cnt[i] <= wait_cnt[i] + WAIT_W'(1);
                end
                o_grant <= gnt;
                if (|gnt) begin
                    o_write_enable <= 1'b1;
                    o_write_addr   <= sel_addr;
                    o_write_data   <= sel_data;
                end else begin
                    o_write_enable <= 1'b0;
                end
            end
        end
    end

    // NOTE: buffer payload needs no reset; it is only observed when buf_valid is set.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (load[i]) begin
                buf_addr[i] <= i_src_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                buf_data[i] <= i_src_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule
